// File: rtl/cacheline_burst_buffer.sv
// ----------------------------------------------------------------------------
// cacheline_burst_buffer
//
// Purpose:
//   Line buffer between a cache controller and a burst memory. A fetch sends
//   one burst read command and deserializes BEATS read beats into a cacheline.
//   A writeback serializes one latched cacheline into BEATS write beats.
//   Both operations end in a common done state that pulses line_resp once.
//
// Ports:
//   clk, rst_n   : rising-edge clock, asynchronous active-low reset
//   line_read    : controller fetch request (held until line_resp)
//   line_write   : controller writeback request (held until line_resp)
//   line_addr    : line address, low log2(LINE_WIDTH/8) bits ignored
//   line_wdata   : writeback line
//   line_rdata   : fetched line, valid while line_resp=1
//   line_resp    : one-cycle completion pulse
//   bmem_addr    : line-aligned burst address
//   bmem_read    : burst read command
//   bmem_write   : write beat valid
//   bmem_wdata   : write beat data
//   bmem_ready   : memory accepts command/beat this cycle
//   bmem_rdata   : read beat data
//   bmem_rvalid  : read beat valid
// ----------------------------------------------------------------------------
package cache_types;
  typedef enum logic [2:0] {
    LINE_IDLE,
    WAIT,
    DESERIALIZE,
    SERIALIZE,
    DESERIALIZE_DONE
  } line_buffer_state_t;
endpackage

module cacheline_burst_buffer #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 256,
  parameter int BEAT_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  line_read,
  input  logic                  line_write,
  input  logic [ADDR_WIDTH-1:0] line_addr,
  input  logic [LINE_WIDTH-1:0] line_wdata,
  output logic [LINE_WIDTH-1:0] line_rdata,
  output logic                  line_resp,
  output logic [ADDR_WIDTH-1:0] bmem_addr,
  output logic                  bmem_read,
  output logic                  bmem_write,
  output logic [BEAT_WIDTH-1:0] bmem_wdata,
  input  logic                  bmem_ready,
  input  logic [BEAT_WIDTH-1:0] bmem_rdata,
  input  logic                  bmem_rvalid
);
  import cache_types::*;

  localparam int BEATS  = LINE_WIDTH / BEAT_WIDTH;
  localparam int CNT_W  = $clog2(BEATS);
  localparam int OFFSET = $clog2(LINE_WIDTH / 8);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  line_buffer_state_t    r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [LINE_WIDTH-1:0] r_wline;
  logic [LINE_WIDTH-1:0] r_rline;
  logic                  r_bmem_read;
  logic                  r_bmem_write;
  logic                  r_line_resp;

  logic [ADDR_WIDTH-1:0] w_aligned_addr;
  logic                  w_unused_offset;

  // Byte offset within the line is dropped; memory only sees whole lines.
  assign w_aligned_addr  = {line_addr[ADDR_WIDTH-1:OFFSET], {OFFSET{1'b0}}};
  assign w_unused_offset = ^line_addr[OFFSET-1:0];

  // The write line is shifted down as beats are accepted, so the current
  // beat always sits in the low bits and the output needs no mux.
  assign bmem_wdata = r_wline[BEAT_WIDTH-1:0];
  assign bmem_addr  = r_addr;
  assign bmem_read  = r_bmem_read;
  assign bmem_write = r_bmem_write;
  assign line_rdata = r_rline;
  assign line_resp  = r_line_resp;

  // Command/beat flags and the resp pulse are set on the transition into
  // the state that owns them, so every output comes straight from a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= LINE_IDLE;
      r_cnt        <= '0;
      r_addr       <= '0;
      r_wline      <= '0;
      r_rline      <= '0;
      r_bmem_read  <= 1'b0;
      r_bmem_write <= 1'b0;
      r_line_resp  <= 1'b0;
    end else begin
      case (r_state)
        LINE_IDLE: begin
          r_cnt       <= '0;
          r_line_resp <= 1'b0;
          // Writeback has priority; a simultaneous fetch stays pending at
          // the controller and is picked up after this op's resp.
          if (line_write) begin
            r_addr       <= w_aligned_addr;
            r_wline      <= line_wdata;
            r_bmem_write <= 1'b1;
            r_state      <= SERIALIZE;
          end else if (line_read) begin
            r_addr      <= w_aligned_addr;
            r_bmem_read <= 1'b1;
            r_state     <= WAIT;
          end
        end

        WAIT: begin
          if (bmem_ready) begin
            r_bmem_read <= 1'b0;
            r_cnt       <= '0;
            r_state     <= DESERIALIZE;
          end
        end

        DESERIALIZE: begin
          if (bmem_rvalid) begin
            for (int b = 0; b < BEATS; b++) begin
              if (r_cnt == CNT_W'(b)) begin
                r_rline[b*BEAT_WIDTH +: BEAT_WIDTH] <= bmem_rdata;
              end
            end
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == LAST_BEAT) begin
              r_line_resp <= 1'b1;
              r_state     <= DESERIALIZE_DONE;
            end
          end
        end

        SERIALIZE: begin
          if (bmem_ready) begin
            r_wline <= r_wline >> BEAT_WIDTH;
            r_cnt   <= r_cnt + 1'b1;
            if (r_cnt == LAST_BEAT) begin
              r_bmem_write <= 1'b0;
              r_line_resp  <= 1'b1;
              r_state      <= DESERIALIZE_DONE;
            end
          end
        end

        DESERIALIZE_DONE: begin
          r_line_resp <= 1'b0;
          r_state     <= LINE_IDLE;
        end

        default: begin
          r_state <= LINE_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cacheline_burst_buffer.sv
// ----------------------------------------------------------------------------
// tb_cacheline_burst_buffer
//
// Purpose:
//   Self-checking bench for cacheline_burst_buffer. A transaction-level model
//   acts as both controller and burst memory: it knows which beats it handed
//   over or which beats it expects to see, and when the single resp pulse
//   must appear, and checks the DUT against that every cycle.
// ----------------------------------------------------------------------------
module tb_cacheline_burst_buffer;
  localparam int AW    = 32;
  localparam int LW    = 256;
  localparam int BW    = 64;
  localparam int BEATS = LW / BW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          line_read = 1'b0;
  logic          line_write = 1'b0;
  logic [AW-1:0] line_addr = '0;
  logic [LW-1:0] line_wdata = '0;
  logic [LW-1:0] line_rdata;
  logic          line_resp;
  logic [AW-1:0] bmem_addr;
  logic          bmem_read;
  logic          bmem_write;
  logic [BW-1:0] bmem_wdata;
  logic          bmem_ready = 1'b0;
  logic [BW-1:0] bmem_rdata = '0;
  logic          bmem_rvalid = 1'b0;

  int            vectors = 0;
  int            miscompares = 0;
  logic [LW-1:0] lastLine = '0;

  cacheline_burst_buffer #(
    .ADDR_WIDTH(AW),
    .LINE_WIDTH(LW),
    .BEAT_WIDTH(BW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .line_read  (line_read),
    .line_write (line_write),
    .line_addr  (line_addr),
    .line_wdata (line_wdata),
    .line_rdata (line_rdata),
    .line_resp  (line_resp),
    .bmem_addr  (bmem_addr),
    .bmem_read  (bmem_read),
    .bmem_write (bmem_write),
    .bmem_wdata (bmem_wdata),
    .bmem_ready (bmem_ready),
    .bmem_rdata (bmem_rdata),
    .bmem_rvalid(bmem_rvalid)
  );

  always #5 clk = ~clk;

  // Single point of comparison: counts every check, reports mismatches.
  task automatic checkOutput(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [LW-1:0] randLine();
    logic [LW-1:0] v;
    v = '0;
    for (int i = 0; i < LW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Runs one controller request (or a write+read pair) to completion while
  // playing the memory side. Inputs change on negedges, outputs are read on
  // negedges, so everything seen reflects the previous rising edge.
  task automatic applyStimulus(input bit doWrite, input bit doRead, input logic [AW-1:0] addr,
                               input logic [LW-1:0] wline, input logic [LW-1:0] rline,
                               input bit randomMode, input int cmdStall, input int stallBeat,
                               input int stallLen, input int gap, input bit noise,
                               input int expLatency);
    bit            curWrite, readPending, cmdAcc, done, firstResp;
    int            cyc, opStart, beat, stallLeft, gapLeft, rdCmdCycles, rdStalls, expRespAt;
    logic [AW-1:0] expAddr;
    bit            stall;

    expAddr = (addr / (LW / 8)) * (LW / 8);
    @(negedge clk);
    line_write  = doWrite;
    line_read   = doRead;
    line_addr   = addr;
    line_wdata  = wline;
    bmem_ready  = 1'b0;
    bmem_rvalid = noise;
    bmem_rdata  = noise ? 64'hDEAD_BEEF_DEAD_BEEF : '0;
    curWrite    = doWrite;
    readPending = doWrite && doRead;
    cmdAcc = 0; done = 0; firstResp = 1;
    cyc = 0; opStart = 0; beat = 0; rdCmdCycles = 0; rdStalls = 0; expRespAt = -1;
    stallLeft = curWrite ? stallLen : cmdStall;
    gapLeft = 0;

    while (!done && cyc < 400) begin
      @(negedge clk);
      cyc++;
      bmem_ready  = 1'b0;
      bmem_rvalid = 1'b0;
      bmem_rdata  = '0;
      checkOutput("rd_wr_excl", LW'(bmem_read & bmem_write), LW'(1'b0));
      checkOutput("resp_timing", LW'(line_resp), LW'(cyc == expRespAt));

      if (line_resp) begin
        if (firstResp && expLatency >= 0)
          checkOutput("latency", LW'(cyc - opStart), LW'(expLatency));
        firstResp = 0;
        if (curWrite) begin
          checkOutput("wr_beats", LW'(beat), LW'(BEATS));
          checkOutput("rdata_kept", line_rdata, lastLine);
        end else begin
          checkOutput("rdata", line_rdata, rline);
          checkOutput("cmd_cycles", LW'(rdCmdCycles), LW'(rdStalls + 1));
          lastLine = rline;
        end
        if (readPending) begin
          // Writeback done; fetch request stays asserted and must follow.
          line_write = 1'b0;
          curWrite = 0; readPending = 0; cmdAcc = 0;
          beat = 0; rdCmdCycles = 0; rdStalls = 0; gapLeft = 0;
          stallLeft = cmdStall;
        end else begin
          line_write = 1'b0;
          line_read  = 1'b0;
          done = 1;
        end
      end else if (!curWrite) begin
        if (bmem_read) begin
          rdCmdCycles++;
          checkOutput("rd_addr", LW'(bmem_addr), LW'(expAddr));
          checkOutput("rd_cmd_after_acc", LW'(cmdAcc), LW'(1'b0));
          stall = randomMode ? ($urandom_range(0, 2) == 0) : (stallLeft > 0);
          if (stall) begin
            stallLeft--;
            rdStalls++;
            if (noise) begin
              bmem_rvalid = 1'b1;
              bmem_rdata  = 64'hBAD0_BAD0_BAD0_BAD0;
            end
          end else begin
            bmem_ready = 1'b1;
            cmdAcc = 1;
          end
        end else if (cmdAcc && beat < BEATS) begin
          stall = randomMode ? ($urandom_range(0, 1) == 0) : (gapLeft > 0);
          if (stall) begin
            gapLeft--;
          end else begin
            bmem_rvalid = 1'b1;
            bmem_rdata  = rline[beat*BW +: BW];
            beat++;
            gapLeft = gap;
            if (beat == BEATS) expRespAt = cyc + 1;
          end
        end
      end else if (bmem_write) begin
        checkOutput("wr_addr", LW'(bmem_addr), LW'(expAddr));
        checkOutput("wr_beat_range", LW'(beat < BEATS), LW'(1'b1));
        if (beat < BEATS) checkOutput("wr_data", LW'(bmem_wdata), LW'(wline[beat*BW +: BW]));
        stall = randomMode ? ($urandom_range(0, 2) == 0) : (beat == stallBeat && stallLeft > 0);
        if (stall) begin
          stallLeft--;
        end else begin
          bmem_ready = 1'b1;
          beat++;
          if (beat == BEATS) expRespAt = cyc + 1;
        end
      end
    end
    checkOutput("op_completed", LW'(done), LW'(1'b1));

    // Cycle after resp: pulse must be gone and the fetched line must hold.
    @(negedge clk);
    checkOutput("resp_one_cycle", LW'(line_resp), LW'(1'b0));
    checkOutput("rdata_hold", line_rdata, lastLine);
  endtask

  // Starts a writeback, lets two beats go, then pulls reset in the middle
  // of the third beat and checks everything drops without a resp.
  task automatic resetMidWrite();
    logic [LW-1:0] wl;
    wl = randLine();
    @(negedge clk);
    line_write = 1'b1;
    line_addr  = $urandom;
    line_wdata = wl;
    bmem_ready = 1'b0;
    @(negedge clk);
    bmem_ready = 1'b1;
    @(negedge clk);
    bmem_ready = 1'b1;
    @(negedge clk);
    bmem_ready = 1'b0;
    checkOutput("rst_wr_before", LW'(bmem_write), LW'(1'b1));
    checkOutput("rst_wdata_before", LW'(bmem_wdata), LW'(wl[2*BW +: BW]));
    #2;
    rst_n = 1'b0;
    line_write = 1'b0;
    #1;
    checkOutput("rst_bmem_write", LW'(bmem_write), LW'(1'b0));
    checkOutput("rst_bmem_read", LW'(bmem_read), LW'(1'b0));
    checkOutput("rst_resp", LW'(line_resp), LW'(1'b0));
    checkOutput("rst_rdata", line_rdata, '0);
    checkOutput("rst_addr", LW'(bmem_addr), '0);
    lastLine = '0;
    repeat (3) begin
      @(negedge clk);
      checkOutput("rst_no_resp", LW'(line_resp), LW'(1'b0));
    end
    rst_n = 1'b1;
  endtask

  initial begin
    logic [LW-1:0] rl, wl;
    #1 rst_n = 1'b0;
    #1;
    checkOutput("reset_rdata", line_rdata, '0);
    checkOutput("reset_resp", LW'(line_resp), LW'(1'b0));
    checkOutput("reset_read", LW'(bmem_read), LW'(1'b0));
    checkOutput("reset_write", LW'(bmem_write), LW'(1'b0));
    checkOutput("reset_addr", LW'(bmem_addr), '0);
    checkOutput("reset_wdata", LW'(bmem_wdata), '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    $display("[TB] reset released");

    // Zero-wait fetch: resp in the 7th cycle counting the request cycle.
    rl = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
          64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    applyStimulus(1'b0, 1'b1, 32'h1234_5678, '0, rl, 1'b0, 0, -1, 0, 0, 1'b0, 2 + BEATS);

    // Writeback with beat 2 stalled for 3 cycles.
    wl = {{16{4'hD}}, {16{4'hC}}, {16{4'hB}}, {16{4'hA}}};
    applyStimulus(1'b1, 1'b0, 32'h0000_1040, wl, '0, 1'b0, 0, 2, 3, 0, 1'b0, 1 + BEATS + 3);

    // Simultaneous requests: writeback first, fetch follows.
    applyStimulus(1'b1, 1'b1, 32'hCAFE_0013, randLine(), randLine(), 1'b0, 0, -1, 0, 0, 1'b0, 1 + BEATS);

    // Fetch with 2-cycle gaps and an rvalid pulse while idle.
    applyStimulus(1'b0, 1'b1, 32'h8000_00FF, '0, randLine(), 1'b0, 0, -1, 0, 2, 1'b1,
                  2 + BEATS + 2 * (BEATS - 1));

    // Fetch with command stalled 5 cycles, junk rvalid during the stall.
    applyStimulus(1'b0, 1'b1, 32'h0BAD_F00D, '0, randLine(), 1'b0, 5, -1, 0, 0, 1'b1, 2 + BEATS + 5);

    // Abort a writeback with reset, then a normal fetch must work.
    resetMidWrite();
    applyStimulus(1'b0, 1'b1, $urandom, '0, randLine(), 1'b0, 0, -1, 0, 0, 1'b0, 2 + BEATS);

    // Random mix of operations with random stalls and gaps.
    for (int n = 0; n < 40; n++) begin
      bit w, r;
      w = $urandom_range(0, 1) == 1;
      r = !w || ($urandom_range(0, 2) == 0);
      applyStimulus(w, r, $urandom, randLine(), randLine(), 1'b1, 0, -1, 0, 0,
                    $urandom_range(0, 1) == 1, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
